// File: rtl/img_load_ctrl.sv
// img_load_ctrl
//   Sequencer and single-port arbiter for the input image RAM (NPIX x DW).
//   IDLE -> LOAD on load_start; LOAD writes an incoming pixel stream to
//   addresses 0..NPIX-1; FULL hands the RAM port to the convolution reader
//   until img_release. clear aborts from any state.
//
//   Optional build macro: IMG_LOAD_TIMEOUT_EN
//     When defined, LOAD aborts to IDLE (err pulse) after TIMEOUT idle cycles.
//     When undefined, no counter is built and err is tied low.
//
// Ports
//   clk, reset          clock, async active-high reset
//   load_start, clear   start a load / soft abort (clear wins over all)
//   pix_valid/ready/data  pixel stream handshake
//   rd_req, rd_addr     reader request, granted only in FULL
//   rd_ack              read address issued this cycle
//   img_release         reader done with image (FULL -> IDLE)
//   mem_addr/wdata/we   registered RAM port
//   img_ready, busy     status (FULL, not IDLE)
//   count               pixels written so far
//   err                 one-cycle load-timeout pulse
module img_load_ctrl #(
  parameter int NPIX    = 784,
  parameter int AW      = 10,
  parameter int DW      = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          clear,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  input  logic          img_release,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          img_ready,
  output logic          busy,
  output logic [AW-1:0] count,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
  state_t state;

  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

`ifdef IMG_LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  // Compare against TIMEOUT-1: the counter is 0 in the cycle after the last
  // beat, so the abort edge lands exactly TIMEOUT cycles after that beat.
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
  logic          err_q;
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign err = 1'b0;
`endif

  assign pix_ready = (state == LOAD);
  assign img_ready = (state == FULL);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rd_ack    <= 1'b0;
`ifdef IMG_LOAD_TIMEOUT_EN
      tcnt      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      // Strobes default low; set only on the cycle that issues them.
      mem_we <= 1'b0;
      rd_ack <= 1'b0;
`ifdef IMG_LOAD_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      if (clear) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (load_start) begin
              state <= LOAD;
              count <= '0;
`ifdef IMG_LOAD_TIMEOUT_EN
              tcnt  <= '0;
`endif
            end
          end
          LOAD: begin
            if (pix_valid) begin
              mem_addr  <= count;
              mem_wdata <= pix_data;
              mem_we    <= 1'b1;
              count     <= count + 1'b1;
`ifdef IMG_LOAD_TIMEOUT_EN
              tcnt      <= '0;
`endif
              // Leaving LOAD on the last beat keeps count <= NPIX and no
              // address >= NPIX can ever be written.
              if (count == LAST) state <= FULL;
            end
`ifdef IMG_LOAD_TIMEOUT_EN
            else if (tcnt == TLIM) begin
              state <= IDLE;
              count <= '0;
              tcnt  <= '0;
              err_q <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
`endif
          end
          FULL: begin
            // Release wins over a same-cycle read request.
            if (img_release) begin
              state <= IDLE;
              count <= '0;
            end else if (rd_req) begin
              mem_addr <= rd_addr;
              rd_ack   <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_img_load_ctrl.sv
module tb_img_load_ctrl;
  localparam int NPIX = 784;
  localparam int AW   = 10;
  localparam int DW   = 8;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start, clear, pix_valid, rd_req, img_release;
  logic [DW-1:0] pix_data;
  logic [AW-1:0] rd_addr;
  logic          pix_ready, rd_ack, mem_we, img_ready, busy, err;
  logic [AW-1:0] mem_addr, count;
  logic [DW-1:0] mem_wdata;

  always #5 clk = ~clk;

  img_load_ctrl #(.NPIX(NPIX), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .clear(clear),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .img_release(img_release), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .img_ready(img_ready), .busy(busy), .count(count),
    .err(err)
  );

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           wq[$];
  logic [AW-1:0] rq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int we_run  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: every write / read grant must match the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        we_run++;
        if (wq.size() == 0) chk("we_unexpected", 1, 0);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", mem_addr, e.a);
          chk("wr_data", mem_wdata, e.d);
        end
      end else we_run = 0;
      if (rd_ack) begin
        if (rq.size() == 0) chk("ack_unexpected", 1, 0);
        else chk("rd_addr", mem_addr, rq.pop_front());
        chk("rd_we_low", mem_we, 0);
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push_beat(input int i);
    wr_t e;
    pix_valid = 1'b1;
    pix_data  = i[7:0];
    e.a = i[AW-1:0];
    e.d = i[7:0];
    wq.push_back(e);
  endtask

  task automatic start_load;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    chk("start_pix_ready", pix_ready, 1);
    chk("start_count", count, 0);
  endtask

  task automatic load_image(input bit gap);
    start_load;
    for (int i = 0; i < NPIX; i++) begin
      push_beat(i);
      tick;
      if (gap) begin
        pix_valid = 1'b0;
        tick;
      end
    end
    pix_valid = 1'b0;
    chk("full_img_ready", img_ready, 1);
    chk("full_pix_ready", pix_ready, 0);
    chk("full_count", count, NPIX);
  endtask

  initial begin
    reset = 1'b1; load_start = 0; clear = 0; pix_valid = 0; rd_req = 0;
    img_release = 0; pix_data = '0; rd_addr = '0;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_img_ready", img_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    tick;

    // Continuous image load
    load_image(1'b0);
    @(negedge clk); #1;
    chk("we_run_784", we_run, NPIX);
    chk("wq_empty1", wq.size(), 0);
    tick;

    // Back-to-back reads, then release (same-cycle rd_req not acked)
    rd_req = 1'b1;
    for (int a = 5; a < 8; a++) begin
      rd_addr = a[AW-1:0];
      rq.push_back(a[AW-1:0]);
      tick;
    end
    rd_addr = 10'd9;
    img_release = 1'b1;
    tick;
    rd_req = 1'b0; img_release = 1'b0;
    chk("rel_busy", busy, 0);
    chk("rel_count", count, 0);
    chk("rel_img_ready", img_ready, 0);
    tick;
    chk("rq_empty1", rq.size(), 0);

    // Gapped load; rd_req in IDLE ignored
    rd_req = 1'b1; rd_addr = 10'd3;
    tick;
    rd_req = 1'b0;
    load_image(1'b1);
    tick;
    chk("wq_empty2", wq.size(), 0);
    img_release = 1'b1;
    tick;
    img_release = 1'b0;
    chk("rel2_busy", busy, 0);

    // rd_req during LOAD ignored; clear at count 300
    start_load;
    for (int i = 0; i < 300; i++) begin
      rd_req  = (i >= 100 && i < 110);
      rd_addr = 10'd5;
      push_beat(i);
      tick;
    end
    rd_req = 1'b0;
    chk("pre_clear_count", count, 300);
    pix_valid = 1'b1; pix_data = 8'hAA; clear = 1'b1;
    tick;
    clear = 1'b0; pix_valid = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_count", count, 0);
    chk("clr_pix_ready", pix_ready, 0);
    chk("clr_mem_we", mem_we, 0);
    tick;

    // clear + img_release in FULL, then load_start + clear
    load_image(1'b0);
    clear = 1'b1; img_release = 1'b1; rd_req = 1'b1; rd_addr = 10'd1;
    tick;
    img_release = 1'b0; rd_req = 1'b0;
    chk("clrrel_busy", busy, 0);
    chk("clrrel_count", count, 0);
    load_start = 1'b1;
    tick;
    load_start = 1'b0; clear = 1'b0;
    chk("clrstart_busy", busy, 0);
    chk("clrstart_pix_ready", pix_ready, 0);
    tick;
    chk("clrstart_busy2", busy, 0);

    // Asynchronous reset mid-load
    start_load;
    for (int i = 0; i < 50; i++) begin
      push_beat(i);
      tick;
    end
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_count", count, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_pix_ready", pix_ready, 0);
    wq.delete();
    pix_valid = 1'b0;
    tick;
    reset = 1'b0;
    tick;

    // Idle handling in LOAD
    start_load;
    for (int i = 0; i < 10; i++) begin
      push_beat(i);
      tick;
    end
    pix_valid = 1'b0;
`ifdef IMG_LOAD_TIMEOUT_EN
    begin
      int n;
      n = 0;
      for (int c = 1; c <= 40; c++) begin
        tick;
        if (err) begin
          n = c;
          break;
        end
      end
      chk("to_err_cycle", n, TO);
      chk("to_busy", busy, 0);
      chk("to_count", count, 0);
      tick;
      chk("to_err_pulse", err, 0);
    end
`else
    for (int c = 0; c < 40; c++) tick;
    chk("noto_busy", busy, 1);
    chk("noto_err", err, 0);
    chk("noto_count", count, 10);
`endif
    chk("wq_empty_end", wq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
